lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the ALU in the NPC execute path.
- Takes the ALU `sum` as the effective address, plus rs2 store data and funct3.
- Runs one memory transaction at a time over a valid/ready request/response bus.
- Returns sign- or zero-extended load data, or a store completion, to writeback.

Parameters:
- ADDR_W, 32, address width; sum from ALU.
- TIMEOUT, 0, max cycles waiting for mem_rsp_valid; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EXU presents a memory op.
- in_ready  out  1  LSU can accept.
- in_addr  in  ADDR_W  effective address (ALU sum).
- in_wdata  in  32  rs2 value for stores.
- in_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- in_is_store  in  1  1 = store, 0 = load.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  word-aligned address ({in_addr[ADDR_W-1:2],2'b00}).
- mem_wen  out  1  write request.
- mem_wdata  out  32  lane-replicated store data.
- mem_wmask  out  4  byte strobes.
- mem_rsp_valid  in  1  response (load data or write ack).
- mem_rdata  in  32  raw word.
- out_valid  out  1  result ready for WBU.
- out_ready  in  1  WBU accepts.
- out_rdata  out  32  formatted load data; 0 for stores and errors.
- out_err  out  1  misaligned, illegal funct3, or timeout.

Behaviour:
- Reset: state=IDLE, all outputs 0 except in_ready=1 (in_ready is a decode of IDLE). Watchdog count=0.
- Reset mid-transaction aborts it. A late mem_rsp_valid arriving in IDLE/REQ is ignored.
- Operand capture: on in_valid&in_ready, latch addr, wdata, funct3, is_store. Inputs are don't-care afterwards.
- Pre-check at accept: err if funct3 ∈ {011,110,111}, or (funct3[1:0]==01 & addr[0]), or (funct3==010 & addr[1:0]!=0). Store with funct3 100/101 is illegal.
- On a pre-check err: no memory request; go to DONE with out_err=1, out_rdata=0.
- FSM IDLE -> REQ -> WAIT -> DONE -> IDLE:
  - IDLE: in_ready=1. Accept -> REQ, or DONE on pre-check err.
  - REQ: mem_req_valid=1; addr/wen/wdata/wmask held stable until mem_req_ready. On mem_req_ready -> WAIT, count cleared.
  - WAIT: on mem_rsp_valid, capture the formatted result -> DONE.
    - If TIMEOUT!=0 and count reaches TIMEOUT-1 without a response -> DONE with out_err=1.
    - A response in the same cycle as the timeout wins; no err.
  - DONE: out_valid=1, outputs registered and stable. On out_ready -> IDLE.
- Responses asserted during REQ are a bus protocol violation and are ignored.
- Store lanes (o = addr[1:0]):
  - SB: wmask=1<<o, wdata={4{b}}.
  - SH: wmask=o[1]?1100:0011, wdata={2{h}}.
  - SW: wmask=1111.
  - Loads: wmask=0000.
- Load extract: byte = rdata[8o+7:8o], half = rdata[16·o[1]+15:16·o[1]]. Sign-extend for 000/001, zero-extend for 100/101.
- Store completion: out_rdata=0, out_err=0 on ack.
- Latency: zero-wait memory (req_ready in REQ, rsp_valid first WAIT cycle) gives out_valid 3 cycles after accept. Pre-check err gives out_valid 1 cycle after accept.
- Throughput: one op in flight; next accept no earlier than the cycle after the DONE handshake.

Decomposition:
- Shared package (npc_pkg): funct3 constants LSU_B/H/W/BU/HU, state encoding localparams, mask constants.
- Sub-module lsu_fmt (combinational): store lane/mask generation and load extract/extend. Reused by the formatting path and by the bench scoreboard.

Test Plan:
- LW addr 0x80000004, zero-wait memory returning 0xDEADBEEF -> mem_addr 0x80000004, wmask 0; out_valid at accept+3; out_rdata 0xDEADBEEF, err 0.
- LB addr 0x80000003, rdata 0x80FF7F01 -> 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x80000002 -> 0x000080FF.
- SH addr 0x10000002, wdata 0x1234ABCD, req_ready delayed 2 cycles -> req fields stable 3 cycles; wmask 1100, wdata 0xABCDABCD; ack -> out_rdata 0, err 0.
- LW addr 0x80000006 -> no mem_req_valid; out_valid next cycle with out_err 1. Funct3 011 -> same.
- TIMEOUT=4, no response -> out_err 1 exactly 4 cycles after entering WAIT; a response on that 4th cycle -> normal data, err 0.
- rst asserted in WAIT, then stray mem_rsp_valid -> outputs 0, in_ready 1, response ignored. out_ready held low 5 cycles in DONE -> out_valid/out_rdata stable, in_ready 0.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg: shared LSU funct3 codes, byte-strobe masks, FSM states and access pre-check.
package npc_pkg;
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_LO   = 4'b0011;
    localparam logic [3:0] MASK_HI   = 4'b1100;
    localparam logic [3:0] MASK_ALL  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

    // Illegal widths, misaligned halves/words, and unsigned-width stores never reach memory.
    function automatic logic pre_err(input logic [2:0] f3, input logic [1:0] off, input logic st);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
            || (f3[1:0] == 2'b01 && off[0])
            || (f3 == LSU_W && off != 2'b00)
            || (st && f3[2]);
    endfunction
endpackage

// File: rtl/lsu_fmt.sv
// lsu_fmt: combinational store lane/strobe generation and load byte/half extract with extension.
module lsu_fmt
    import npc_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic        i_is_store,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = i_rdata >> {i_off, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_wmask = !i_is_store ? MASK_NONE :
                  i_funct3[1:0] == 2'b00 ? 4'b0001 << i_off :
                  i_funct3[1:0] == 2'b01 ? (i_off[1] ? MASK_HI : MASK_LO) : MASK_ALL;
        o_wdata = i_funct3[1:0] == 2'b00 ? {4{i_wdata[7:0]}} :
                  i_funct3[1:0] == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
        o_rdata = i_funct3 == LSU_B  ? {{24{w_byte[7]}}, w_byte} :
                  i_funct3 == LSU_H  ? {{16{w_half[15]}}, w_half} :
                  i_funct3 == LSU_BU ? {24'd0, w_byte} :
                  i_funct3 == LSU_HU ? {16'd0, w_half} : i_rdata;
    end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between EXU and a valid/ready memory bus.
module lsu
    import npc_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [2:0]        in_funct3,
    input  logic              in_is_store,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rdata,
    output logic              out_err
);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    lsu_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_funct3;
    logic              r_is_store;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [31:0]       r_cnt;
    logic [31:0]       w_load;
    logic              w_pre_err;

    assign w_pre_err     = pre_err(in_funct3, in_addr[1:0], in_is_store);
    assign in_ready      = r_state == S_IDLE;
    assign mem_req_valid = r_state == S_REQ;
    assign out_valid     = r_state == S_DONE;
    assign mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wen       = r_is_store;
    assign out_rdata     = r_rdata;
    assign out_err       = r_err;

    // Request fields derive from captured operands, so they hold steady through REQ.
    lsu_fmt u_fmt (
        .i_funct3  (r_funct3),
        .i_off     (r_addr[1:0]),
        .i_is_store(r_is_store),
        .i_wdata   (r_wdata),
        .i_rdata   (mem_rdata),
        .o_wmask   (mem_wmask),
        .o_wdata   (mem_wdata),
        .o_rdata   (w_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_funct3   <= '0;
            r_is_store <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_addr     <= in_addr;
                    r_wdata    <= in_wdata;
                    r_funct3   <= in_funct3;
                    r_is_store <= in_is_store;
                    r_rdata    <= '0;
                    r_err      <= w_pre_err;
                    r_state    <= w_pre_err ? S_DONE : S_REQ;
                end
                S_REQ: if (mem_req_ready) begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (mem_rsp_valid) begin
                    r_rdata <= r_is_store ? 32'd0 : w_load;
                    r_err   <= 1'b0;
                    r_state <= S_DONE;
                end else if (TIMEOUT != 0 && r_cnt == TO_LAST) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                    r_state <= S_DONE;
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
                S_DONE: if (out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed vector table plus hand-written multi-cycle sequences for lsu.
module tb_lsu;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_addr = 0;
    logic [31:0] in_wdata = 0;
    logic [2:0]  in_funct3 = 0;
    logic        in_is_store = 0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid = 0;
    logic [31:0] mem_rdata = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] out_rdata;
    logic        out_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_funct3(in_funct3), .in_is_store(in_is_store),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        st;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_wmask;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3, input logic st);
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 1);
        in_valid = 1; in_addr = a; in_wdata = wd; in_funct3 = f3; in_is_store = st;
    endtask

    task automatic scramble();
        in_valid = 0; in_addr = 32'hFFFF_FFFF; in_wdata = 32'h5555_5555; in_funct3 = 3'b111; in_is_store = 1;
    endtask

    task automatic finish_done();
        out_ready = 1;
        @(negedge clk);
        out_ready = 0; mem_rsp_valid = 0;
        chk("idle_after_done", {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat; bit seen, prev, done;
        accept(v.addr, v.wdata, v.f3, v.st);
        mem_rdata = v.rdata; mem_req_ready = 1;
        lat = 0; seen = 0; prev = 0; done = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            scramble();
            mem_rsp_valid = prev;
            prev = 0;
            if (mem_req_valid && !seen) begin
                seen = 1;
                prev = mem_req_ready;
                chk($sformatf("v%0d_addr", idx), mem_addr, v.e_addr);
                chk($sformatf("v%0d_wen", idx), {31'd0, mem_wen}, {31'd0, v.st});
                chk($sformatf("v%0d_wmask", idx), {28'd0, mem_wmask}, {28'd0, v.e_wmask});
                chk($sformatf("v%0d_wdata", idx), mem_wdata, v.e_wdata);
            end
            if (out_valid) begin
                done = 1;
                chk($sformatf("v%0d_lat", idx), lat, v.e_lat);
                chk($sformatf("v%0d_rdata", idx), out_rdata, v.e_rdata);
                chk($sformatf("v%0d_err", idx), {31'd0, out_err}, {31'd0, v.e_err});
                chk($sformatf("v%0d_req_seen", idx), {31'd0, seen}, {31'd0, !v.e_err});
            end
        end
        if (!done) chk($sformatf("v%0d_out_valid_timeout", idx), 0, 1);
        finish_done();
    endtask

    initial begin
        //          addr           wdata          f3      st  rdata          e_addr         wmask    e_wdata        e_rdata        err lat
        vecs[0]  = '{32'h8000_0004, 32'h0,         3'b010, 0, 32'hDEAD_BEEF, 32'h8000_0004, 4'b0000, 32'h0,         32'hDEAD_BEEF, 0, 3};
        vecs[1]  = '{32'h8000_0003, 32'h0,         3'b000, 0, 32'h80FF_7F01, 32'h8000_0000, 4'b0000, 32'h0,         32'hFFFF_FF80, 0, 3};
        vecs[2]  = '{32'h8000_0003, 32'h0,         3'b100, 0, 32'h80FF_7F01, 32'h8000_0000, 4'b0000, 32'h0,         32'h0000_0080, 0, 3};
        vecs[3]  = '{32'h8000_0002, 32'h0,         3'b101, 0, 32'h80FF_7F01, 32'h8000_0000, 4'b0000, 32'h0,         32'h0000_80FF, 0, 3};
        vecs[4]  = '{32'h8000_0002, 32'h0,         3'b001, 0, 32'h80FF_7F01, 32'h8000_0000, 4'b0000, 32'h0,         32'hFFFF_80FF, 0, 3};
        vecs[5]  = '{32'h8000_0001, 32'h0,         3'b000, 0, 32'h80FF_7F01, 32'h8000_0000, 4'b0000, 32'h0,         32'h0000_007F, 0, 3};
        vecs[6]  = '{32'h8000_0000, 32'h0,         3'b001, 0, 32'h1234_8765, 32'h8000_0000, 4'b0000, 32'h0,         32'hFFFF_8765, 0, 3};
        vecs[7]  = '{32'h1000_0001, 32'h0000_00A5, 3'b000, 1, 32'hFFFF_FFFF, 32'h1000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0,         0, 3};
        vecs[8]  = '{32'h2000_0000, 32'hCAFE_F00D, 3'b010, 1, 32'hFFFF_FFFF, 32'h2000_0000, 4'b1111, 32'hCAFE_F00D, 32'h0,         0, 3};
        vecs[9]  = '{32'h1000_0000, 32'h1234_ABCD, 3'b001, 1, 32'hFFFF_FFFF, 32'h1000_0000, 4'b0011, 32'hABCD_ABCD, 32'h0,         0, 3};
        vecs[10] = '{32'h8000_0006, 32'h0,         3'b010, 0, 32'hFFFF_FFFF, 32'h0,         4'b0000, 32'h0,         32'h0,         1, 1};
        vecs[11] = '{32'h8000_0000, 32'h0,         3'b011, 0, 32'hFFFF_FFFF, 32'h0,         4'b0000, 32'h0,         32'h0,         1, 1};
        vecs[12] = '{32'h8000_0000, 32'h0,         3'b100, 1, 32'hFFFF_FFFF, 32'h0,         4'b0000, 32'h0,         32'h0,         1, 1};
        vecs[13] = '{32'h8000_0001, 32'h0,         3'b001, 0, 32'hFFFF_FFFF, 32'h0,         4'b0000, 32'h0,         32'h0,         1, 1};
        vecs[14] = '{32'h8000_0000, 32'h0,         3'b111, 0, 32'hFFFF_FFFF, 32'h0,         4'b0000, 32'h0,         32'h0,         1, 1};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_outs", {28'd0, mem_req_valid, mem_wen, out_valid, out_err}, 0);
        chk("rst_rdata", out_rdata, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wmask", {28'd0, mem_wmask}, 0);
        rst = 0;

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        // SH with request held off two cycles; fields must stay put while inputs change.
        mem_req_ready = 0;
        accept(32'h1000_0002, 32'h1234_ABCD, 3'b001, 1);
        mem_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            scramble();
            chk($sformatf("sh_req_valid_%0d", c), {31'd0, mem_req_valid}, 1);
            chk($sformatf("sh_addr_%0d", c), mem_addr, 32'h1000_0000);
            chk($sformatf("sh_wmask_%0d", c), {28'd0, mem_wmask}, 32'hC);
            chk($sformatf("sh_wdata_%0d", c), mem_wdata, 32'hABCD_ABCD);
            chk($sformatf("sh_wen_%0d", c), {31'd0, mem_wen}, 1);
        end
        mem_req_ready = 1;
        @(negedge clk);
        mem_rsp_valid = 1;
        chk("sh_req_dropped", {31'd0, mem_req_valid}, 0);
        @(negedge clk);
        mem_rsp_valid = 0;
        chk("sh_out_valid", {31'd0, out_valid}, 1);
        chk("sh_rdata", out_rdata, 0);
        chk("sh_err", {31'd0, out_err}, 0);
        finish_done();

        // Watchdog: no response, error lands after four WAIT cycles.
        accept(32'h8000_0000, 32'h0, 3'b010, 0);
        @(negedge clk); scramble();
        chk("to_req", {31'd0, mem_req_valid}, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("to_wait_%0d", c), {31'd0, out_valid}, 0);
        end
        @(negedge clk);
        chk("to_out_valid", {31'd0, out_valid}, 1);
        chk("to_err", {31'd0, out_err}, 1);
        chk("to_rdata", out_rdata, 0);
        finish_done();

        // Response on the final WAIT cycle beats the watchdog.
        accept(32'h8000_0000, 32'h0, 3'b010, 0);
        @(negedge clk); scramble();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 3) begin mem_rsp_valid = 1; mem_rdata = 32'h1122_3344; end
        end
        @(negedge clk);
        mem_rsp_valid = 0;
        chk("race_out_valid", {31'd0, out_valid}, 1);
        chk("race_err", {31'd0, out_err}, 0);
        chk("race_rdata", out_rdata, 32'h1122_3344);
        finish_done();

        // Reset while waiting, then a stray response must be ignored.
        accept(32'h8000_0004, 32'h0, 3'b010, 0);
        @(negedge clk); scramble();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; mem_rsp_valid = 1; mem_rdata = 32'hBAD0_BAD0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rstw_ready_%0d", c), {31'd0, in_ready}, 1);
            chk($sformatf("rstw_flags_%0d", c), {30'd0, out_valid, mem_req_valid}, 0);
            chk($sformatf("rstw_rdata_%0d", c), out_rdata, 0);
            chk($sformatf("rstw_err_%0d", c), {31'd0, out_err}, 0);
            @(negedge clk);
        end
        mem_rsp_valid = 0;

        // DONE held with out_ready low for five cycles.
        accept(32'h8000_0008, 32'h0, 3'b010, 0);
        mem_rdata = 32'h5A5A_5A5A;
        @(negedge clk); scramble();
        @(negedge clk); mem_rsp_valid = 1;
        @(negedge clk); mem_rsp_valid = 0; mem_rdata = 32'h0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold_valid_%0d", c), {31'd0, out_valid}, 1);
            chk($sformatf("hold_rdata_%0d", c), out_rdata, 32'h5A5A_5A5A);
            chk($sformatf("hold_ready_%0d", c), {31'd0, in_ready}, 0);
            if (c < 4) @(negedge clk);
        end
        finish_done();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
